error_countdown_display: RTL and testbench
==========================================

Name: error_countdown_display

Overview:
Parametrised error-timeout and status-display engine for the matrix calculator. Generalises the top level's fixed countdown, led[0] error indication and 4-digit seven-segment scan to a configurable clock, digit count and runtime-programmable timeout. It also adds restart and cancel handling and a one-cycle expiry pulse. The FSM controller drives start/cancel; expired feeds back as the controller's timeout_expired.

Parameters:
CLK_FREQ_HZ, 100000000, input clock frequency; one second = CLK_FREQ_HZ cycles
NUM_DIGITS, 4, number of seven-segment digits scanned (min 3)
SCAN_HZ, 1000, full-frame refresh rate; digit dwell DWELL = CLK_FREQ_HZ/(SCAN_HZ*NUM_DIGITS) cycles (min 1)
TIMEOUT_MIN, 5, smallest accepted timeout in seconds
TIMEOUT_MAX, 15, largest accepted timeout in seconds
TIMEOUT_DEFAULT, 10, timeout loaded at reset

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
cfg_we  in  1  timeout config write strobe
cfg_sec  in  4  requested timeout in seconds
start  in  1  begin/restart countdown (level sampled each cycle)
cancel  in  1  abort countdown
op_code  in  4  operation type shown on digit 0
busy  out  1  countdown running
remaining  out  4  seconds left
cfg_reject  out  1  one-cycle pulse: config write refused
expired  out  1  one-cycle pulse at timeout
err_led  out  1  error indicator
seg  out  8  segments, active-low, {dp,g,f,e,d,c,b,a}
an  out  NUM_DIGITS  digit enables, active-low, one-hot-low

Behaviour:
- Interface: one clock clk; reset rst_n is asynchronous and active-low.
- Reset values: busy=0, remaining=0, cfg_reject=0, expired=0, err_led=0, seg=8'hFF, an=all ones, timeout register=TIMEOUT_DEFAULT, prescaler=0, scan counter=0, digit index=0, FSM=IDLE.
- FSM states: IDLE, COUNT.
- Config write: accepted only in IDLE with TIMEOUT_MIN<=cfg_sec<=TIMEOUT_MAX; the value takes effect the next cycle.
  - Out-of-range value, or any write in COUNT: register unchanged, cfg_reject=1 for exactly the following cycle.
- IDLE -> COUNT on start: remaining<=timeout register, prescaler<=0, busy<=1, err_led<=1, all registered one cycle after start.
- COUNT:
  - Prescaler counts 0..CLK_FREQ_HZ-1; a tick occurs when it wraps.
  - On a tick, remaining decrements.
  - Tick with remaining==1: remaining<=0, expired=1 for one cycle, busy<=0, err_led<=0, -> IDLE. Total duration is exactly timeout*CLK_FREQ_HZ cycles after the start-capture edge.
  - start while in COUNT: restart; reload remaining, clear prescaler. A restart coinciding with a final tick suppresses expired.
  - cancel: -> IDLE, remaining<=0, busy<=0, err_led<=0, no expired pulse.
- Priority: cancel > start > tick. start and cancel together in IDLE: stay IDLE.
- Prescaler is held at 0 in IDLE.
- Display scan:
  - Runs continuously from reset in both states.
  - Digit index advances every DWELL cycles, wrapping NUM_DIGITS-1 -> 0.
  - an drives low only the bit at the current digit index. The first digit is enabled DWELL cycles after reset release; an stays all ones until then.
- Digit content:
  - Digit 0: hex glyph of op_code (0-9, A-F).
  - Digit 1: remaining%10.
  - Digit 2: remaining/10, blank (8'hFF) when zero.
  - Digits >=3: blank.
  - seg is registered alongside an.
- Glyphs: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E; dp is always off.
- Mid-operation reset: all state returns to reset values immediately; no expired pulse.

Optional Feature:
BLINK_EN:
- Defined: during COUNT, err_led toggles every CLK_FREQ_HZ/4 cycles (2 Hz blink). Phase is high at the start-capture edge and realigned on restart.
- Undefined: err_led is steady 1 throughout COUNT.
- Both builds: err_led=0 in IDLE.

Test Plan:
All scenarios use CLK_FREQ_HZ=100, SCAN_HZ=5, NUM_DIGITS=4 (DWELL=5).
- Reset release, no stimulus -> remaining=0, busy=0, err_led=0, an=1111 for 5 cycles, then cycles 1110,1101,1011,0111 each for 5 cycles; digit 1 seg=C0; digits 2 and 3 seg=FF.
- cfg_we with cfg_sec=7, then start -> busy=1 next cycle; remaining 7->6 after 100 cycles; expired pulses exactly 700 cycles after the start edge; busy=0 and err_led=0 the same cycle.
- cfg_sec=3 and cfg_sec=12 while busy -> cfg_reject pulses once each, timeout register unchanged; cfg_sec=12 in IDLE accepted; after start, digit 2 shows F9 (1) and digit 1 shows A4 (2).
- start at remaining=4, then start again 50 cycles later -> remaining reloads to the timeout value; expiry occurs timeout*100 cycles after the second start.
- start and cancel asserted together while counting at remaining=5 -> IDLE, remaining=0, no expired pulse; op_code=4'hA shows seg=88 on digit 0.
- rst_n pulled low mid-count for 1 cycle -> all outputs at reset values asynchronously; no expired pulse ever follows.

Source files
------------

// File: rtl/error_countdown_display.sv
// Error-timeout countdown with a multiplexed seven-segment status display.
// It counts down a programmable timeout and pulses `expired` once when it runs out.
// The display scan runs all the time: it shows the op_code on digit 0 and the remaining seconds on digits 1-2.
//
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   cfg_we, cfg_sec     : timeout write strobe and value in seconds (IDLE only, range-checked)
//   start, cancel       : begin/restart and abort of the countdown (cancel wins)
//   op_code             : operation type shown as a hex glyph on digit 0
//   busy, remaining     : countdown running flag and whole seconds left
//   cfg_reject, expired : one-cycle pulses (refused config write, timeout reached)
//   err_led             : error indicator, lit while counting
//   seg, an             : active-low segments {dp,g,f,e,d,c,b,a} and one-hot-low digit enables
//
// Build option: define BLINK_EN to make err_led blink at 2 Hz while counting.
// If BLINK_EN is not defined, err_led stays steady while counting.

module error_countdown_display #(
  parameter int CLK_FREQ_HZ     = 100000000,
  parameter int NUM_DIGITS      = 4,
  parameter int SCAN_HZ         = 1000,
  parameter int TIMEOUT_MIN     = 5,
  parameter int TIMEOUT_MAX     = 15,
  parameter int TIMEOUT_DEFAULT = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_we,
  input  logic [3:0]            cfg_sec,
  input  logic                  start,
  input  logic                  cancel,
  input  logic [3:0]            op_code,
  output logic                  busy,
  output logic [3:0]            remaining,
  output logic                  cfg_reject,
  output logic                  expired,
  output logic                  err_led,
  output logic [7:0]            seg,
  output logic [NUM_DIGITS-1:0] an
);

  localparam int PW        = (CLK_FREQ_HZ > 1) ? $clog2(CLK_FREQ_HZ) : 1;
  localparam int DWELL_RAW = CLK_FREQ_HZ / (SCAN_HZ * NUM_DIGITS);
  localparam int DWELL     = (DWELL_RAW < 1) ? 1 : DWELL_RAW;
  localparam int SW        = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int DIGW      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [3:0] TO_MIN = 4'(TIMEOUT_MIN);
  localparam logic [3:0] TO_MAX = 4'(TIMEOUT_MAX);
  localparam logic [3:0] TO_DEF = 4'(TIMEOUT_DEFAULT);

`ifdef BLINK_EN
  localparam int BLINK_Q = (CLK_FREQ_HZ / 4 < 1) ? 1 : CLK_FREQ_HZ / 4;
  localparam int BW      = (BLINK_Q > 1) ? $clog2(BLINK_Q) : 1;
`endif

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_COUNT = 1'b1
  } state_e;

  // ------------------------------------------------------------------
  // Countdown state
  // ------------------------------------------------------------------
  state_e          state_q, state_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [3:0]      remaining_q, remaining_d;
  logic [3:0]      timeout_q, timeout_d;
  logic            busy_q, busy_d;
  logic            expired_q, expired_d;
  logic            cfg_reject_q, cfg_reject_d;
  logic            err_led_q, err_led_d;
  logic            tick;
  logic            cfg_ok;
`ifdef BLINK_EN
  logic [BW-1:0]   blink_q, blink_d;
`endif

  // ------------------------------------------------------------------
  // Display scan state
  // ------------------------------------------------------------------
  logic [SW-1:0]         scan_q, scan_d;
  logic [DIGW-1:0]       dig_q, dig_d;
  logic                  scan_on_q, scan_on_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [7:0]            seg_q, seg_d;
  logic                  scan_wrap;
  logic [3:0]            rem_ones;
  logic                  rem_tens;

  function automatic logic [7:0] hex_glyph(input logic [3:0] v);
    logic [7:0] g;
    case (v)
      4'h0: g = 8'hC0;
      4'h1: g = 8'hF9;
      4'h2: g = 8'hA4;
      4'h3: g = 8'hB0;
      4'h4: g = 8'h99;
      4'h5: g = 8'h92;
      4'h6: g = 8'h82;
      4'h7: g = 8'hF8;
      4'h8: g = 8'h80;
      4'h9: g = 8'h90;
      4'hA: g = 8'h88;
      4'hB: g = 8'h83;
      4'hC: g = 8'hC6;
      4'hD: g = 8'hA1;
      4'hE: g = 8'h86;
      default: g = 8'h8E;
    endcase
    return g;
  endfunction

  // ------------------------------------------------------------------
  // Countdown next-state logic
  // ------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    presc_d      = presc_q;
    remaining_d  = remaining_q;
    timeout_d    = timeout_q;
    busy_d       = busy_q;
    expired_d    = 1'b0;
    cfg_reject_d = 1'b0;
    err_led_d    = err_led_q;
`ifdef BLINK_EN
    blink_d      = blink_q;
`endif

    tick   = (presc_q == PW'(CLK_FREQ_HZ - 1));
    cfg_ok = (state_q == ST_IDLE) && (cfg_sec >= TO_MIN) && (cfg_sec <= TO_MAX);

    // A write that arrives together with start is still taken. The countdown
    // that starts in the same cycle loads the old timeout.
    if (cfg_we) begin
      if (cfg_ok) begin
        timeout_d = cfg_sec;
      end else begin
        cfg_reject_d = 1'b1;
      end
    end

    case (state_q)
      ST_IDLE: begin
        presc_d = '0;
        if (start && !cancel) begin
          state_d     = ST_COUNT;
          remaining_d = timeout_q;
          busy_d      = 1'b1;
          err_led_d   = 1'b1;
`ifdef BLINK_EN
          blink_d     = '0;
`endif
        end
      end

      ST_COUNT: begin
        if (cancel) begin
          state_d     = ST_IDLE;
          presc_d     = '0;
          remaining_d = '0;
          busy_d      = 1'b0;
          err_led_d   = 1'b0;
`ifdef BLINK_EN
          blink_d     = '0;
`endif
        end else if (start) begin
          // A restart also wins over a final tick in the same cycle, so
          // that tick gives no expired pulse.
          presc_d     = '0;
          remaining_d = timeout_q;
          err_led_d   = 1'b1;
`ifdef BLINK_EN
          blink_d     = '0;
`endif
        end else begin
          presc_d = tick ? '0 : presc_q + PW'(1);
`ifdef BLINK_EN
          if (blink_q == BW'(BLINK_Q - 1)) begin
            blink_d   = '0;
            err_led_d = ~err_led_q;
          end else begin
            blink_d   = blink_q + BW'(1);
          end
`endif
          if (tick) begin
            if (remaining_q <= 4'd1) begin
              state_d     = ST_IDLE;
              remaining_d = '0;
              expired_d   = 1'b1;
              busy_d      = 1'b0;
              err_led_d   = 1'b0;
            end else begin
              remaining_d = remaining_q - 4'd1;
            end
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ------------------------------------------------------------------
  // Display scan next-state logic
  // ------------------------------------------------------------------
  always_comb begin
    scan_wrap = (scan_q == SW'(DWELL - 1));
    scan_d    = scan_wrap ? '0 : scan_q + SW'(1);
    // The first dwell after reset shows nothing. Digit 0 becomes the first
    // digit shown, and the index only advances on later wraps.
    scan_on_d = scan_on_q | scan_wrap;
    dig_d     = dig_q;
    if (scan_wrap && scan_on_q) begin
      dig_d = (dig_q == DIGW'(NUM_DIGITS - 1)) ? '0 : dig_q + DIGW'(1);
    end

    rem_tens = (remaining_q >= 4'd10);
    rem_ones = rem_tens ? (remaining_q - 4'd10) : remaining_q;

    an_d  = '1;
    seg_d = 8'hFF;
    if (scan_on_d) begin
      an_d[dig_d] = 1'b0;
      if (dig_d == DIGW'(0)) begin
        seg_d = hex_glyph(op_code);
      end else if (dig_d == DIGW'(1)) begin
        seg_d = hex_glyph(rem_ones);
      end else if (dig_d == DIGW'(2)) begin
        seg_d = rem_tens ? hex_glyph(4'd1) : 8'hFF;
      end
    end
  end

  // ------------------------------------------------------------------
  // State registers
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      presc_q      <= '0;
      remaining_q  <= '0;
      timeout_q    <= TO_DEF;
      busy_q       <= 1'b0;
      expired_q    <= 1'b0;
      cfg_reject_q <= 1'b0;
      err_led_q    <= 1'b0;
`ifdef BLINK_EN
      blink_q      <= '0;
`endif
      scan_q       <= '0;
      dig_q        <= '0;
      scan_on_q    <= 1'b0;
      an_q         <= '1;
      seg_q        <= 8'hFF;
    end else begin
      state_q      <= state_d;
      presc_q      <= presc_d;
      remaining_q  <= remaining_d;
      timeout_q    <= timeout_d;
      busy_q       <= busy_d;
      expired_q    <= expired_d;
      cfg_reject_q <= cfg_reject_d;
      err_led_q    <= err_led_d;
`ifdef BLINK_EN
      blink_q      <= blink_d;
`endif
      scan_q       <= scan_d;
      dig_q        <= dig_d;
      scan_on_q    <= scan_on_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
    end
  end

  assign busy       = busy_q;
  assign remaining  = remaining_q;
  assign cfg_reject = cfg_reject_q;
  assign expired    = expired_q;
  assign err_led    = err_led_q;
  assign seg        = seg_q;
  assign an         = an_q;

endmodule

// File: tb/tb_error_countdown_display.sv
// Bench for error_countdown_display, run with a 100-cycle "second" and a 5-cycle digit dwell.
// The reference model measures elapsed cycles since the countdown started.
// Every output is compared on every cycle.

module tb_error_countdown_display;

  localparam int CLK   = 100;
  localparam int ND    = 4;
  localparam int SCAN  = 5;
  localparam int DWELL = CLK / (SCAN * ND);
  localparam int TMIN  = 5;
  localparam int TMAX  = 15;
  localparam int TDEF  = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cfg_we = 1'b0;
  logic [3:0]    cfg_sec = 4'd0;
  logic          start = 1'b0;
  logic          cancel = 1'b0;
  logic [3:0]    op_code = 4'd0;
  logic          busy;
  logic [3:0]    remaining;
  logic          cfg_reject;
  logic          expired;
  logic          err_led;
  logic [7:0]    seg;
  logic [ND-1:0] an;

  error_countdown_display #(
    .CLK_FREQ_HZ    (CLK),
    .NUM_DIGITS     (ND),
    .SCAN_HZ        (SCAN),
    .TIMEOUT_MIN    (TMIN),
    .TIMEOUT_MAX    (TMAX),
    .TIMEOUT_DEFAULT(TDEF)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_we    (cfg_we),
    .cfg_sec   (cfg_sec),
    .start     (start),
    .cancel    (cancel),
    .op_code   (op_code),
    .busy      (busy),
    .remaining (remaining),
    .cfg_reject(cfg_reject),
    .expired   (expired),
    .err_led   (err_led),
    .seg       (seg),
    .an        (an)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  logic [7:0] glyph [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                             8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  // Reference model state
  int m_timeout;   // programmed timeout in seconds
  bit m_active;    // countdown running
  int m_elapsed;   // cycles since the start-capture edge
  int m_to;        // timeout captured at start
  bit m_expired;
  bit m_reject;
  int m_k;         // clock edges since reset release
  bit rnd_op = 1'b1;

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic int m_rem();
    return m_active ? (m_to - m_elapsed / CLK) : 0;
  endfunction

  function automatic int m_err();
`ifdef BLINK_EN
    return (m_active && ((m_elapsed / (CLK / 4)) % 2 == 0)) ? 1 : 0;
`else
    return m_active ? 1 : 0;
`endif
  endfunction

  function automatic int m_digit();
    return (m_k / DWELL - 1) % ND;
  endfunction

  function automatic int m_an();
    if (m_k < DWELL) return (1 << ND) - 1;
    return ((1 << ND) - 1) & ~(1 << m_digit());
  endfunction

  function automatic int m_seg(input int rem, input int op);
    int d;
    if (m_k < DWELL) return 'hFF;
    d = m_digit();
    if (d == 0) return int'(glyph[op]);
    if (d == 1) return int'(glyph[rem % 10]);
    if (d == 2) return (rem / 10 == 0) ? 'hFF : int'(glyph[rem / 10]);
    return 'hFF;
  endfunction

  task automatic model_reset();
    m_timeout = TDEF;
    m_active  = 1'b0;
    m_elapsed = 0;
    m_to      = 0;
    m_expired = 1'b0;
    m_reject  = 1'b0;
    m_k       = 0;
  endtask

  task automatic model_step();
    bit was_idle;
    int old_to;
    was_idle  = !m_active;
    old_to    = m_timeout;
    m_expired = 1'b0;
    m_reject  = 1'b0;
    if (cfg_we) begin
      if (was_idle && int'(cfg_sec) >= TMIN && int'(cfg_sec) <= TMAX) m_timeout = int'(cfg_sec);
      else m_reject = 1'b1;
    end
    if (cancel) begin
      m_active = 1'b0;
    end else if (start) begin
      m_active  = 1'b1;
      m_elapsed = 0;
      m_to      = old_to;
    end else if (m_active) begin
      m_elapsed++;
      if (m_elapsed == m_to * CLK) begin
        m_active  = 1'b0;
        m_expired = 1'b1;
      end
    end
    m_k++;
  endtask

  task automatic check_all(input int prev_rem, input int op);
    chk("busy",       int'(busy),       m_active ? 1 : 0);
    chk("remaining",  int'(remaining),  m_rem());
    chk("cfg_reject", int'(cfg_reject), m_reject ? 1 : 0);
    chk("expired",    int'(expired),    m_expired ? 1 : 0);
    chk("err_led",    int'(err_led),    m_err());
    chk("an",         int'(an),         m_an());
    chk("seg",        int'(seg),        m_seg(prev_rem, op));
  endtask

  // One clock: inputs stay stable across the edge, and outputs are sampled 1 time unit after it.
  task automatic step();
    int prev_rem;
    int op;
    if (rnd_op) op_code = 4'($urandom_range(0, 15));
    prev_rem = m_rem();
    op       = int'(op_code);
    @(posedge clk);
    #1;
    model_step();
    check_all(prev_rem, op);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic pulse_start();
    start = 1'b1; step(); start = 1'b0;
  endtask

  task automatic cfg_write(input int v);
    cfg_we = 1'b1; cfg_sec = 4'(v); step(); cfg_we = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"},  int'(busy),       0);
    chk({tag, "_rem"},   int'(remaining),  0);
    chk({tag, "_rej"},   int'(cfg_reject), 0);
    chk({tag, "_exp"},   int'(expired),    0);
    chk({tag, "_err"},   int'(err_led),    0);
    chk({tag, "_seg"},   int'(seg),        'hFF);
    chk({tag, "_an"},    int'(an),         (1 << ND) - 1);
  endtask

  task automatic wait_expiry(input string tag, input int want);
    int n;
    n = 0;
    while (n <= want + 100) begin
      step();
      n++;
      if (expired) break;
    end
    chk(tag, n, want);
  endtask

  task automatic run_until_rem(input string tag, input int r);
    for (int i = 0; i < 2000 && int'(remaining) != r; i++) step();
    chk(tag, int'(remaining), r);
  endtask

  initial begin
    model_reset();

    // Reset asserted: outputs at reset values
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    rst_n = 1'b1;

    // Idle scan pattern after reset release
    steps(30);

    // Program 7 s, start, let it expire
    cfg_write(7);
    pulse_start();
    wait_expiry("expiry_7s", 700);
    steps(10);

    // Writes while busy are refused; timeout stays 7
    pulse_start();
    steps(20);
    cfg_write(3);
    steps(2);
    cfg_write(12);
    steps(2);
    cancel = 1'b1; step(); cancel = 1'b0;
    pulse_start();
    steps(5);
    chk("timeout_kept", int'(remaining), 7);
    cancel = 1'b1; step(); cancel = 1'b0;

    // Out-of-range write in IDLE is refused; 12 is accepted
    cfg_write(3);
    cfg_write(12);
    pulse_start();
    steps(60);

    // Restart at remaining=4, restart again 50 cycles later, then expire
    run_until_rem("reach_rem4", 4);
    pulse_start();
    steps(49);
    pulse_start();
    wait_expiry("expiry_restart", 1200);
    steps(5);

    // start+cancel together at remaining=5, with op_code A held on digit 0
    pulse_start();
    run_until_rem("reach_rem5", 5);
    rnd_op  = 1'b0;
    op_code = 4'hA;
    start = 1'b1; cancel = 1'b1; step(); start = 1'b0; cancel = 1'b0;
    steps(40);
    rnd_op = 1'b1;

    // start+cancel together in IDLE: stays idle
    start = 1'b1; cancel = 1'b1; step(); start = 1'b0; cancel = 1'b0;
    steps(5);

    // Reset applied in the middle of a count
    pulse_start();
    steps(150);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    steps(1600);

    // Randomised traffic
    for (int i = 0; i < 5000; i++) begin
      cfg_we  = ($urandom_range(0, 49) == 0);
      cfg_sec = 4'($urandom_range(0, 15));
      start   = ($urandom_range(0, 599) == 0);
      cancel  = ($urandom_range(0, 1499) == 0);
      step();
    end
    cfg_we = 1'b0; start = 1'b0; cancel = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
